pll_rst_seq_ctl: RTL

- Power-up and recovery sequencer for the clock/reset subsystem.
- Drives the PLL reset and qualifies PLL lock, then releases the per-domain active-low resets in a fixed order with programmable gaps.
- Re-runs the sequence on lock loss, lock timeout or a software reset request.
- Sits between the PLL and the reset synchronisers that feed the LED datapath domains.

---
 rtl/pll_rst_seq_ctl_if.sv | 24 ++
 rtl/pll_rst_seq_ctl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq_ctl_if.sv
// Sequencer-facing bundle: PLL lock/areset, software request, per-domain resets and diagnostics.
// master is the sequencer side; slave is the PLL / reset-tree side.
interface pll_rst_seq_ctl_if #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_WIDTH   = 8
);
  logic                   pll_locked_in;
  logic                   sw_rst_req_in;
  logic                   pll_areset_out;
  logic [NUM_DOMAINS-1:0] rst_n_out;
  logic                   sys_ready_out;
  logic [CNT_WIDTH-1:0]   retry_cnt_out;
  logic [CNT_WIDTH-1:0]   lock_loss_cnt_out;

  modport master (
    input  pll_locked_in, sw_rst_req_in,
    output pll_areset_out, rst_n_out, sys_ready_out, retry_cnt_out, lock_loss_cnt_out
  );

  modport slave (
    output pll_locked_in, sw_rst_req_in,
    input  pll_areset_out, rst_n_out, sys_ready_out, retry_cnt_out, lock_loss_cnt_out
  );
endinterface

// File: rtl/pll_rst_seq_ctl.sv
// PLL reset / lock qualification and ordered per-domain reset release, re-run on lock loss or sw request.
// All outputs registered with the state; lock input sees 2 cycles of synchroniser latency.
module pll_rst_seq_ctl #(
  parameter int NUM_DOMAINS   = 3,
  parameter int ARESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int LOCK_STABLE   = 1024,
  parameter int STAGE_GAP     = 64,
  parameter int SW_HOLD       = 16,
  parameter int CNT_WIDTH     = 8
) (
  input logic              clk_in,
  input logic              rst_in,
  pll_rst_seq_ctl_if.master bus
);

  localparam int MAX_A = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int MAX_B = (ARESET_CYCLES > STAGE_GAP) ? ARESET_CYCLES : STAGE_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_T = (MAX_C > SW_HOLD) ? MAX_C : SW_HOLD;
  localparam int TMR_W = $clog2(MAX_T + 1);

  localparam logic [TMR_W-1:0] AR_LAST   = TMR_W'(ARESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ST_LAST   = TMR_W'(LOCK_STABLE - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(STAGE_GAP - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(SW_HOLD - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_SW_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   lock_meta_q, lock_s_q;
  logic                   pll_areset_q, pll_areset_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic [NUM_DOMAINS-1:0] rel_mask_d;
  logic                   sys_ready_q, sys_ready_d;
  logic [CNT_WIDTH-1:0]   retry_cnt_q, retry_cnt_d;
  logic [CNT_WIDTH-1:0]   lock_loss_cnt_q, lock_loss_cnt_d;
  logic                   domains_live;

  // Domains may be (partly) out of reset only in these states; lock loss and sw requests act here.
  assign domains_live = (state_q == S_RELEASE) || (state_q == S_RUN) || (state_q == S_SW_HOLD);

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q + TMR_W'(1);
    rel_mask_d      = rst_n_q;
    retry_cnt_d     = retry_cnt_q;
    lock_loss_cnt_d = lock_loss_cnt_q;

    if (domains_live && !lock_s_q) begin
      state_d = S_WAIT_LOCK;
      timer_d = '0;
      if (lock_loss_cnt_q != '1) lock_loss_cnt_d = lock_loss_cnt_q + CNT_WIDTH'(1);
    end else if (domains_live && bus.sw_rst_req_in) begin
      state_d = S_SW_HOLD;
      timer_d = '0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (timer_q == AR_LAST) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            // The detecting cycle already counts as the first stable lock cycle.
            state_d = S_STABLE;
            timer_d = TMR_W'(1);
          end else if (timer_q == TO_LAST) begin
            state_d = S_PLL_RST;
            timer_d = '0;
            if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + CNT_WIDTH'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q >= ST_LAST) begin
            state_d    = S_RELEASE;
            timer_d    = '0;
            rel_mask_d = NUM_DOMAINS'(1);
          end
        end
        S_RELEASE: begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            if (rst_n_q[NUM_DOMAINS-1]) state_d = S_RUN;
            else rel_mask_d = (rst_n_q << 1) | NUM_DOMAINS'(1);
          end
        end
        S_RUN: begin
          timer_d = '0;
        end
        S_SW_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_d    = S_RELEASE;
            timer_d    = '0;
            rel_mask_d = NUM_DOMAINS'(1);
          end
        end
        default: begin
          state_d = S_PLL_RST;
          timer_d = '0;
        end
      endcase
    end

    pll_areset_d = (state_d == S_PLL_RST);
    sys_ready_d  = (state_d == S_RUN);
    if (state_d == S_RELEASE)  rst_n_d = rel_mask_d;
    else if (state_d == S_RUN) rst_n_d = '1;
    else                       rst_n_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= S_PLL_RST;
      timer_q         <= '0;
      lock_meta_q     <= 1'b0;
      lock_s_q        <= 1'b0;
      pll_areset_q    <= 1'b1;
      rst_n_q         <= '0;
      sys_ready_q     <= 1'b0;
      retry_cnt_q     <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      lock_meta_q     <= bus.pll_locked_in;
      lock_s_q        <= lock_meta_q;
      pll_areset_q    <= pll_areset_d;
      rst_n_q         <= rst_n_d;
      sys_ready_q     <= sys_ready_d;
      retry_cnt_q     <= retry_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  assign bus.pll_areset_out    = pll_areset_q;
  assign bus.rst_n_out         = rst_n_q;
  assign bus.sys_ready_out     = sys_ready_q;
  assign bus.retry_cnt_out     = retry_cnt_q;
  assign bus.lock_loss_cnt_out = lock_loss_cnt_q;

endmodule
